// File: rtl/alu_request_arbiter.sv
// Two-port round-robin arbiter in front of the shared integer ALU.
// One transaction in flight: accept (IDLE), drive the ALU (EXEC), return result (RESP).
module alu_request_arbiter #(
  parameter int XLEN       = 64,
  parameter int SEL_SIZE   = 4,
  parameter int SHIFT_SIZE = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [SEL_SIZE-1:0]   req0_sel,
  input  logic [SHIFT_SIZE-1:0] req0_shift_amt,
  input  logic [XLEN-1:0]       req0_a,
  input  logic [XLEN-1:0]       req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [SEL_SIZE-1:0]   req1_sel,
  input  logic [SHIFT_SIZE-1:0] req1_shift_amt,
  input  logic [XLEN-1:0]       req1_a,
  input  logic [XLEN-1:0]       req1_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [XLEN-1:0]       rsp0_data,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [XLEN-1:0]       rsp1_data,
  output logic                  alu_enable,
  output logic [SEL_SIZE-1:0]   alu_sel,
  output logic [SHIFT_SIZE-1:0] alu_shift_amt,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  input  logic [XLEN-1:0]       alu_data_out,
  output logic                  busy,
  output logic                  owner
);

  // state | meaning
  // IDLE  | waiting for a request; ready may assert to the granted port
  // EXEC  | operands held on the ALU for one cycle, result captured at edge
  // RESP  | result presented on owner's response channel until consumed
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state, state_next;
  logic                  prio;
  logic                  owner_q;
  logic [SEL_SIZE-1:0]   sel_q;
  logic [SHIFT_SIZE-1:0] shift_q;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [XLEN-1:0]       result_q;
  logic                  grant0;
  logic                  grant1;
  logic                  rsp_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner_q  <= 1'b0;
      sel_q    <= '0;
      shift_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (grant0) begin
        owner_q <= 1'b0;
        sel_q   <= req0_sel;
        shift_q <= req0_shift_amt;
        a_q     <= req0_a;
        b_q     <= req0_b;
      end else if (grant1) begin
        owner_q <= 1'b1;
        sel_q   <= req1_sel;
        shift_q <= req1_shift_amt;
        a_q     <= req1_a;
        b_q     <= req1_b;
      end
      if (state == EXEC) result_q <= alu_data_out;
      if (rsp_hs) prio <= ~owner_q;
    end
  end

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rsp_hs     = 1'b0;
    alu_enable = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    case (state)
      IDLE: begin
        // Pointer only breaks ties; a lone requester is always granted.
        grant0 = req0_valid && (!req1_valid || !prio);
        grant1 = req1_valid && (!req0_valid || prio);
        if (grant0 || grant1) state_next = EXEC;
      end
      EXEC: begin
        alu_enable = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (owner_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = result_q;
          rsp_hs     = rsp1_ready;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = result_q;
          rsp_hs     = rsp0_ready;
        end
        if (rsp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign alu_sel       = sel_q;
  assign alu_shift_amt = shift_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign busy          = (state != IDLE);
  assign owner         = owner_q;

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
Shares the single integer ALU between two requesters: port 0 is the execute stage and port 1 is the auxiliary/extension unit. Each request uses a valid/ready handshake. The block grants requests round-robin, latches the operands, and drives the ALU for exactly one cycle. It registers the result and returns it on the winning requester's response channel. One transaction is in flight at a time.

Parameters:
XLEN, 64, operand/result width
SEL_SIZE, 4, ALU op-select width (ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9, LUI=10, AUIPC=11)
SHIFT_SIZE, 5, shift-amount width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid / req1_valid  in  1  request pending
req0_ready / req1_ready  out  1  request accepted this cycle
req0_sel / req1_sel  in  SEL_SIZE  ALU operation
req0_shift_amt / req1_shift_amt  in  SHIFT_SIZE  shift amount
req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
rsp0_valid / rsp1_valid  out  1  result available
rsp0_ready / rsp1_ready  in  1  requester consumes result
rsp0_data / rsp1_data  out  XLEN  result
alu_enable  out  1  ALU enable
alu_sel  out  SEL_SIZE  to ALU sel
alu_shift_amt  out  SHIFT_SIZE  to ALU shift_amt
alu_a, alu_b  out  XLEN  to ALU operands
alu_data_out  in  XLEN  combinational ALU result
busy  out  1  state != IDLE
owner  out  1  index of current/last granted requester

Behaviour:
- Reset (rst=1 at edge): state=IDLE, priority pointer=0, owner=0. Operand/result regs=0. All rsp*_valid=0, alu_enable=0, busy=0. Reset mid-transaction discards it; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE, neither valid: stay; req*_ready=0.
- IDLE, one valid: grant it.
- IDLE, both valid: grant the port equal to the priority pointer.
- IDLE grant: reqN_ready=1 combinationally, same cycle, granted port only. At the edge, latch sel/shift_amt/a/b into operand regs, set owner=N, go EXEC. Ready never asserts outside IDLE.
- EXEC (exactly 1 cycle): alu_enable=1; alu_* driven from operand regs. At the edge, capture alu_data_out into the result reg, go RESP.
- RESP: rsp[owner]_valid=1 and rsp[owner]_data=result reg; the other response valid stays 0. Hold valid/data stable until rsp[owner]_ready=1.
- RESP handshake edge: go IDLE; priority pointer = ~owner (round-robin).
- rsp_ready asserted while not in RESP, or on the non-owner port: ignored.
- alu_a/alu_b/alu_sel/alu_shift_amt always reflect operand regs. alu_enable=0 in IDLE and RESP.
- rsp*_data = 0 when the matching valid is 0.
- Latency: accept at cycle T, EXEC at T+1, rsp_valid at T+2 (if rsp_ready is held high, handshake at T+2). Back to IDLE at T+3. Peak throughput is 1 op per 3 cycles.
- A request arriving in the same cycle as a RESP handshake is not accepted until the following IDLE cycle.
- Undefined sel values (12-15) are forwarded unchanged. The ALU returns 0 and the block returns 0; it does not flag an error.
- Dropping req_valid before ready is allowed; no grant occurs.
- No arithmetic is performed in this block; results pass bit-exact from the ALU.

Test Plan:
- Single op on port 0: ADD, a=5, b=7 -> req0_ready at T; alu_enable only at T+1; rsp0_valid=1, rsp0_data=12 at T+2; rsp1_valid stays 0.
- Simultaneous requests after reset: port 0 SUB 10-3, port 1 XOR 0xF0^0x0F, both valid, rsp ready tied high -> port 0 granted first (rsp0_data=7). Port 1 granted next IDLE (rsp1_data=0xFF). Then with both valid again, port 0 wins (alternation).
- Response backpressure: port 1 SRA a=-16, shift_amt=2, rsp1_ready low for 5 cycles -> rsp1_valid/data (-4) held stable; no new grant while port 0 is valid; IDLE the cycle after ready rises.
- Reset in EXEC: assert rst the cycle after grant -> no rsp valid ever issued; busy=0, pointer=0; a fresh port-1 request after reset is served normally.
- Undefined sel=13 on port 0 -> rsp0_data=0, FSM completes normally. SLTU a=-1, b=1 -> 0; SLT a=-1, b=1 -> 1.
- Pass-through ops: LUI a=0x12345 -> rsp_data=0x12345000. AUIPC with a=1, b=0x1000 -> 0x2000.
